// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
package demux_pkg;
  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  localparam int CH0 = 0;
  localparam int CH1 = 1;
  localparam int CH2 = 2;
  localparam int CH3 = 3;
endpackage

// File: rtl/demux_slot.sv
// One-entry output slot with wrapping delivery counter; load to valid in 1 cycle.
// Backpressure: slot_ready is high when empty or draining this cycle.
module demux_slot #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_ready
);
  logic deliver;

  assign deliver    = valid && ready;
  assign slot_ready = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      if (deliver) begin
        cnt <= cnt + CNT_W'(1);
      end
      // A load in the same cycle as a delivery keeps the slot full.
      if (load) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (deliver) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demux: input word lands in slot {sel1,sel0} one cycle after accept.
// Backpressure: in_ready depends only on the targeted slot; other full slots never block.
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel0,
  input  logic             in_sel1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);
  logic [SEL_W-1:0]   tgt;
  logic [NUM_OUT-1:0] slot_rdy;
  logic [NUM_OUT-1:0] load;
  logic [WIDTH-1:0]   slot_dat [NUM_OUT];
  logic [CNT_W-1:0]   slot_cnt [NUM_OUT];

  assign tgt      = {in_sel1, in_sel0};
  assign in_ready = !rst && slot_rdy[tgt];

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    assign load[i] = in_valid && in_ready && (tgt == SEL_W'(i));

    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[i]),
      .load_data  (in_data),
      .ready      (out_ready[i]),
      .data       (slot_dat[i]),
      .valid      (out_valid[i]),
      .cnt        (slot_cnt[i]),
      .slot_ready (slot_rdy[i])
    );
  end

  assign out_data0 = slot_dat[CH0];
  assign out_data1 = slot_dat[CH1];
  assign out_data2 = slot_dat[CH2];
  assign out_data3 = slot_dat[CH3];
  assign cnt0      = slot_cnt[CH0];
  assign cnt1      = slot_cnt[CH1];
  assign cnt2      = slot_cnt[CH2];
  assign cnt3      = slot_cnt[CH3];
endmodule

// File: tb/tb_demux_1to4_reg.sv
// Bench for demux_1to4_reg: per-cycle reference comparison plus directed literal checks.
module tb_demux_1to4_reg;
  localparam int WIDTH   = 1;
  localparam int CNT_W   = 2;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel0, in_sel1, in_valid, in_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]       out_valid, out_ready;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

  demux_1to4_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel0(in_sel0), .in_sel1(in_sel1),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  logic last_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each channel holds at most one pending word and a count of
  // words taken by its consumer.
  bit pend [4];
  int word [4];
  int taken [4];

  always @(posedge clk) begin
    int  t;
    bit  acc;
    bit  dlv [4];
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pend[i] = 0; word[i] = 0; taken[i] = 0;
      end
    end else begin
      t   = {in_sel1, in_sel0};
      acc = in_valid && (!pend[t] || out_ready[t]);
      for (int i = 0; i < 4; i++) begin
        dlv[i] = pend[i] && out_ready[i];
        if (dlv[i]) begin
          taken[i] = (taken[i] + 1) % CNT_MOD;
          pend[i]  = 0;
        end
      end
      if (acc) begin
        pend[t] = 1;
        word[t] = int'(in_data);
      end
    end
  end

  logic [WIDTH-1:0] od [4];
  logic [CNT_W-1:0] oc [4];
  assign od[0] = out_data0; assign od[1] = out_data1;
  assign od[2] = out_data2; assign od[3] = out_data3;
  assign oc[0] = cnt0; assign oc[1] = cnt1; assign oc[2] = cnt2; assign oc[3] = cnt3;

  always @(negedge clk) begin
    if (chk_on) begin
      int  t;
      logic [3:0] ev;
      t = {in_sel1, in_sel0};
      check("in_ready", 32'(in_ready), 32'(!rst && (!pend[t] || out_ready[t])));
      for (int i = 0; i < 4; i++) ev[i] = pend[i];
      check("out_valid", 32'(out_valid), 32'(ev));
      for (int i = 0; i < 4; i++) begin
        check($sformatf("out_data%0d", i), 32'(od[i]), 32'(word[i]));
        check($sformatf("cnt%0d", i), 32'(oc[i]), 32'(taken[i]));
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] r);
    in_valid  = v;
    in_sel1   = s[1];
    in_sel0   = s[0];
    in_data   = d;
    out_ready = r;
    #2;
    last_rdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  logic [CNT_W-1:0] cnt3_seq [5];

  initial begin
    cnt3_seq[0] = 2'd1; cnt3_seq[1] = 2'd2; cnt3_seq[2] = 2'd3;
    cnt3_seq[3] = 2'd0; cnt3_seq[4] = 2'd1;

    // Reset for two cycles with a word presented.
    rst = 1'b1;
    in_valid = 1'b1; in_sel0 = 1'b0; in_sel1 = 1'b0; in_data = 1'b1; out_ready = 4'h0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    drive(1'b1, 2'd0, 1'b1, 4'h0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cnts", 32'({cnt0, cnt1, cnt2, cnt3}), 32'd0);
    check("rst_data", 32'({out_data0, out_data1, out_data2, out_data3}), 32'd0);

    // One word per channel on consecutive cycles, all consumers ready.
    rst = 1'b0;
    drive(1'b1, 2'd0, 1'b1, 4'hF);
    check("lat_valid0", 32'(out_valid), 32'b0001);
    check("lat_data0", 32'(out_data0), 32'd1);
    drive(1'b1, 2'd1, 1'b0, 4'hF);
    check("lat_valid1", 32'(out_valid), 32'b0010);
    drive(1'b1, 2'd2, 1'b1, 4'hF);
    check("lat_valid2", 32'(out_valid), 32'b0100);
    drive(1'b1, 2'd3, 1'b0, 4'hF);
    check("lat_valid3", 32'(out_valid), 32'b1000);
    drive(1'b0, 2'd0, 1'b0, 4'hF);
    check("route_data", 32'({out_data0, out_data1, out_data2, out_data3}), 32'b1010);
    check("route_cnts", 32'({cnt0, cnt1, cnt2, cnt3}), 32'b01_01_01_01);
    check("route_empty", 32'(out_valid), 32'd0);

    // Blocked target versus free retarget.
    drive(1'b1, 2'd2, 1'b1, 4'h0);
    check("hold_valid", 32'(out_valid), 32'b0100);
    drive(1'b1, 2'd2, 1'b0, 4'h0);
    check("blocked_rdy", 32'(last_rdy), 32'd0);
    check("blocked_data2", 32'(out_data2), 32'd1);
    drive(1'b1, 2'd0, 1'b1, 4'h0);
    check("retarget_rdy", 32'(last_rdy), 32'd1);
    check("retarget_valid", 32'(out_valid), 32'b0101);

    // Full slot drained and reloaded in the same cycle.
    drive(1'b1, 2'd1, 1'b1, 4'h0);
    check("ch1_full", 32'(out_valid), 32'b0111);
    drive(1'b1, 2'd1, 1'b0, 4'b0010);
    check("thru_rdy", 32'(last_rdy), 32'd1);
    check("thru_valid", 32'(out_valid), 32'b0111);
    check("thru_data1", 32'(out_data1), 32'd0);
    check("thru_cnt1", 32'(cnt1), 32'd2);

    // Reset with every slot full and a word presented.
    drive(1'b1, 2'd3, 1'b1, 4'h0);
    check("all_full", 32'(out_valid), 32'b1111);
    rst = 1'b1;
    drive(1'b1, 2'd3, 1'b1, 4'h0);
    check("mid_rst_rdy", 32'(last_rdy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnts", 32'({cnt0, cnt1, cnt2, cnt3}), 32'd0);
    rst = 1'b0;
    drive(1'b0, 2'd3, 1'b1, 4'hF);
    check("no_stale", 32'(out_valid), 32'd0);
    check("no_stale_cnt3", 32'(cnt3), 32'd0);

    // Five back-to-back words on ch3 through a 2-bit counter.
    for (int k = 0; k < 6; k++) begin
      drive(k < 5, 2'd3, WIDTH'(k), 4'b1000);
      if (k >= 1) check($sformatf("cnt3_wrap%0d", k), 32'(cnt3), 32'(cnt3_seq[k-1]));
    end
    drive(1'b0, 2'd0, 1'b0, 4'h0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
